decode_cycle: RTL
=================

// Module: decode_cycle
// PURPOSE
//  RV32I decode stage of the 5-stage pipeline; consumes IF/ID outputs (InstrD, PCD, PCPlus4D).
//  Holds the 32x32 register file, written from the writeback stage.
//  Contains the main/ALU control decoder and the immediate extender.
//  Registers everything into the ID/EX pipeline register feeding the execute stage.
// PARAMETERS
//  XLEN   32  datapath width
//  NREG   32  register count (x0 hardwired to zero)
// PORTS
//  CLK          in   1     clock, all state updates on rising edge
//  Rst          in   1     reset, asynchronous, active-low
//  InstrD       in   32    instruction from IF/ID
//  PCD          in   32    PC of InstrD
//  PCPlus4D     in   32    PCD+4
//  RegWriteW    in   1     writeback enable
//  RDW          in   5     writeback destination register
//  ResultW      in   32    writeback data
//  FlushE       in   1     insert bubble into ID/EX (taken branch/jump)
//  RegWriteE    out  1     ID/EX: register write enable
//  ResultSrcE   out  2     ID/EX: 00 ALU, 01 memory, 10 PC+4
//  MemWriteE    out  1     ID/EX: store enable
//  JumpE        out  1     ID/EX: jal
//  BranchE      out  1     ID/EX: beq
//  ALUSrcE      out  1     ID/EX: 0 RD2, 1 immediate
//  ALUControlE  out  3     ID/EX: 000 add, 001 sub, 010 and, 011 or, 101 slt
//  RD1E, RD2E   out  32    ID/EX: register operands
//  ImmExtE      out  32    ID/EX: sign-extended immediate
//  RS1E, RS2E   out  5     ID/EX: source register numbers (for hazard unit)
//  RDE          out  5     ID/EX: destination register number
//  PCE, PCPlus4E out 32    ID/EX: PC, PC+4
// BEHAVIOUR
//  Reset (Rst=0, async): all 31 writable registers and every ID/EX output = 0.
//  Register file: write on rising CLK when RegWriteW=1 and RDW!=0; writes to x0 ignored.
//  Reads are combinational on InstrD[19:15]/[24:20]; x0 always reads 0.
//  Write-through: if RegWriteW=1, RDW!=0 and RDW==rs, the read returns ResultW in the same cycle.
//  Decode by opcode InstrD[6:0]:
//   0000011 lw:   RegWrite=1 ResultSrc=01 ALUSrc=1 Imm=I  ALU=add
//   0100011 sw:   MemWrite=1 ALUSrc=1 Imm=S ALU=add
//   0110011 R:    RegWrite=1 ALUSrc=0, ALU from funct3/funct7[5]
//   0010011 I-ALU: RegWrite=1 ALUSrc=1 Imm=I, ALU from funct3 (funct7 ignored)
//   1100011 beq:  Branch=1 ALUSrc=0 Imm=B ALU=sub
//   1101111 jal:  RegWrite=1 Jump=1 ResultSrc=10 Imm=J
//   other:        all controls 0 (bubble); data fields still registered
//  ALU map (funct3): 000 add, or sub when R-type with funct7[5]=1; 010 slt; 110 or; 111 and.
//   Unlisted funct3 -> add.
//  Immediates (sign bit InstrD[31]):
//   I = [31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; J = {[31],[19:12],[20],[30:21],0}.
//  ID/EX register: 1-cycle latency; every E output reflects the D-side values sampled at the previous rising edge.
//  FlushE=1 at an edge: all ID/EX outputs load 0 (bubble), overriding decode.
//  Reset mid-operation clears in-flight ID/EX contents immediately; the register file is cleared as well.
// TESTING
//  Reset: Rst=0 -> all E outputs 0; after release, read x1..x31 -> 0.
//  Write x5=0xDEADBEEF (RegWriteW=1, RDW=5); InstrD=add x6,x5,x0 -> next edge RD1E=0xDEADBEEF, ALUControlE=000, RegWriteE=1.
//  Write-through: same cycle RegWriteW=1, RDW=7, ResultW=0x1234, InstrD reads x7 -> RD1E=0x1234 after the edge.
//  x0 write: RDW=0, ResultW=0xFFFFFFFF -> a later read of x0 gives RD1E=0.
//  Immediates: lw imm=-4 -> ImmExtE=0xFFFFFFFC; beq offset -8 -> 0xFFFFFFF8; jal +2048 -> 0x00000800, ResultSrcE=10.
//  FlushE=1 with sw in InstrD -> MemWriteE=0 and all E outputs 0; next cycle with FlushE=0 decodes normally.

Source files
------------

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: register file, control decoder, immediate extender, ID/EX register
module decode_cycle #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            CLK,
   input  logic            Rst,
   input  logic [XLEN-1:0] InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic            RegWriteE,
   output logic [1:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RS1E,
   output logic [4:0]      RS2E,
   output logic [4:0]      RDE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immSel_t;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_RTYPE, ALU_ITYPE} aluMode_t;

   logic [XLEN-1:0] regs [0:NREG-1];

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [4:0] rs1D, rs2D, rdD;

   logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD;
   logic [1:0]      resultSrcD;
   logic [2:0]      aluControlD;
   immSel_t         immSel;
   aluMode_t        aluMode;
   logic [XLEN-1:0] rd1D, rd2D, immExtD;

   assign opcode   = InstrD[6:0];
   assign funct3   = InstrD[14:12];
   assign funct7b5 = InstrD[30];
   assign rs1D     = InstrD[19:15];
   assign rs2D     = InstrD[24:20];
   assign rdD      = InstrD[11:7];

   // Register file write port; x0 is never written so it stays zero after reset.
   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (RegWriteW && (RDW != 5'd0)) begin
         regs[RDW] <= ResultW;
      end
   end

   // Combinational reads with write-through so a same-cycle writeback is seen by decode.
   always_comb begin
      rd1D = '0;
      rd2D = '0;
      if (rs1D != 5'd0) rd1D = (RegWriteW && (RDW == rs1D)) ? ResultW : regs[rs1D];
      if (rs2D != 5'd0) rd2D = (RegWriteW && (RDW == rs2D)) ? ResultW : regs[rs2D];
   end

   // Main decoder: unknown opcodes leave every control at zero, i.e. a bubble.
   always_comb begin
      regWriteD  = 1'b0;
      resultSrcD = 2'b00;
      memWriteD  = 1'b0;
      jumpD      = 1'b0;
      branchD    = 1'b0;
      aluSrcD    = 1'b0;
      immSel     = IMM_I;
      aluMode    = ALU_ADD;
      case (opcode)
         OP_LW: begin
            regWriteD  = 1'b1;
            resultSrcD = 2'b01;
            aluSrcD    = 1'b1;
         end
         OP_SW: begin
            memWriteD = 1'b1;
            aluSrcD   = 1'b1;
            immSel    = IMM_S;
         end
         OP_R: begin
            regWriteD = 1'b1;
            aluMode   = ALU_RTYPE;
         end
         OP_IALU: begin
            regWriteD = 1'b1;
            aluSrcD   = 1'b1;
            aluMode   = ALU_ITYPE;
         end
         OP_BEQ: begin
            branchD = 1'b1;
            immSel  = IMM_B;
            aluMode = ALU_SUB;
         end
         OP_JAL: begin
            regWriteD  = 1'b1;
            jumpD      = 1'b1;
            resultSrcD = 2'b10;
            immSel     = IMM_J;
         end
         default: ;
      endcase
   end

   // ALU control: funct7[5] selects sub only for register-register ops, never for immediates.
   always_comb begin
      aluControlD = 3'b000;
      case (aluMode)
         ALU_ADD: aluControlD = 3'b000;
         ALU_SUB: aluControlD = 3'b001;
         default: begin
            case (funct3)
               3'b000:  aluControlD = (aluMode == ALU_RTYPE && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  aluControlD = 3'b101;
               3'b110:  aluControlD = 3'b011;
               3'b111:  aluControlD = 3'b010;
               default: aluControlD = 3'b000;
            endcase
         end
      endcase
   end

   // Immediate extender; every format sign-extends from InstrD[31].
   always_comb begin
      immExtD = '0;
      case (immSel)
         IMM_I: immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S: immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B: immExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J: immExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: immExtD = '0;
      endcase
   end

   // ID/EX pipeline register; a flush loads an all-zero bubble over the decoded values.
   always_ff @(posedge CLK or negedge Rst) begin
      if (!Rst || FlushE) begin
         RegWriteE   <= 1'b0;
         ResultSrcE  <= 2'b00;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         RS1E        <= 5'd0;
         RS2E        <= 5'd0;
         RDE         <= 5'd0;
         PCE         <= '0;
         PCPlus4E    <= '0;
      end else begin
         RegWriteE   <= regWriteD;
         ResultSrcE  <= resultSrcD;
         MemWriteE   <= memWriteD;
         JumpE       <= jumpD;
         BranchE     <= branchD;
         ALUSrcE     <= aluSrcD;
         ALUControlE <= aluControlD;
         RD1E        <= rd1D;
         RD2E        <= rd2D;
         ImmExtE     <= immExtD;
         RS1E        <= rs1D;
         RS2E        <= rs2D;
         RDE         <= rdD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
      end
   end

endmodule
